// File: rtl/red_centroid_calc_pkg.sv
// Shared definitions for the red-object centroid calculator.
// Holds the default frame geometry, the accumulator / divider widths,
// the divider iteration count, the control FSM encoding and the
// red-pixel classifier.
package red_centroid_calc_pkg;

   localparam int unsigned IMG_WIDTH_DEF  = 640;
   localparam int unsigned IMG_HEIGHT_DEF = 480;

   localparam int unsigned X_W        = 10;  // column counter / centroid_x width
   localparam int unsigned Y_W        = 9;   // row counter / centroid_y width
   localparam int unsigned SUM_W      = 28;  // coordinate sum / dividend width
   localparam int unsigned CNT_W      = 19;  // red-pixel count / divisor width
   localparam int unsigned DIV_CYCLES = 28;  // one iteration per dividend bit
   localparam int unsigned STEP_W     = $clog2(DIV_CYCLES + 1);

   typedef enum logic [1:0] {
      ST_ACCUM   = 2'd0,
      ST_DIVIDE  = 2'd1,
      ST_PUBLISH = 2'd2
   } state_t;

   // RGB444 pixel: [11:8] R, [7:4] G, [3:0] B
   function automatic logic is_red(input logic [11:0] px,
                                   input logic [3:0]  r_min,
                                   input logic [3:0]  g_max,
                                   input logic [3:0]  b_max);
      return (px[11:8] >= r_min) && (px[7:4] <= g_max) && (px[3:0] <= b_max);
   endfunction

endpackage

// File: rtl/red_centroid_calc_divider.sv
// seq_divider: restoring unsigned divider, SUM_W-bit dividend by CNT_W-bit
// divisor, exactly DIV_CYCLES iterations after start.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   start        load operands and (re)start; aborts a division in flight
//   dividend     SUM_W-bit dividend, sampled on start
//   divisor      CNT_W-bit divisor, sampled on start
//   busy         iterations in progress
//   done         one-cycle pulse once quotient is final
//   quotient     floor(dividend / divisor); all ones for a zero divisor
module seq_divider
   import red_centroid_calc_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [SUM_W-1:0] dividend,
   input  logic [CNT_W-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [SUM_W-1:0] quotient
);

   // work starts as the dividend and is shifted left one bit per step,
   // collecting quotient bits from the right.
   logic [SUM_W-1:0]  work;
   logic [CNT_W-1:0]  rem;
   logic [CNT_W-1:0]  dsr;
   logic [STEP_W-1:0] steps;
   logic [CNT_W:0]    shifted;
   logic [CNT_W-1:0]  diff;
   logic              take;

   // rem < dsr always holds, so the shifted partial remainder needs one
   // extra bit; when the subtraction is taken the result fits in CNT_W bits.
   always_comb begin
      shifted = {rem, work[SUM_W-1]};
      take    = shifted >= {1'b0, dsr};
      diff    = shifted[CNT_W-1:0] - dsr;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         work  <= '0;
         rem   <= '0;
         dsr   <= '0;
         steps <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         done <= 1'b0;
         if (start) begin
            work  <= dividend;
            dsr   <= divisor;
            rem   <= '0;
            steps <= STEP_W'(DIV_CYCLES);
            busy  <= 1'b1;
         end else if (busy) begin
            work  <= {work[SUM_W-2:0], take};
            rem   <= take ? diff : shifted[CNT_W-1:0];
            steps <= steps - STEP_W'(1);
            if (steps == STEP_W'(1)) begin
               busy <= 1'b0;
               done <= 1'b1;
            end
         end
      end
   end

   assign quotient = work;

endmodule

// File: rtl/red_centroid_calc.sv
// red_centroid_calc: accumulates the coordinates of red pixels over a
// raster-order frame and publishes the centroid after the frame ends.
// Ports:
//   i_clk, i_rstn        clock, asynchronous active-low reset
//   i_data_valid, i_data RGB444 pixel stream, one pixel per valid cycle
//   o_centroid_x/y       centroid of the last completed frame with an object
//   o_red_object_valid   last completed frame held >= MIN_PIXELS red pixels
//   o_end_frame          one-cycle pulse when the outputs above are updated
module red_centroid_calc
   import red_centroid_calc_pkg::*;
#(
   parameter int unsigned IMG_WIDTH  = IMG_WIDTH_DEF,
   parameter int unsigned IMG_HEIGHT = IMG_HEIGHT_DEF,
   parameter logic [3:0]  R_MIN      = 4'hA,
   parameter logic [3:0]  G_MAX      = 4'h5,
   parameter logic [3:0]  B_MAX      = 4'h5,
   parameter int unsigned MIN_PIXELS = 64
)(
   input  logic           i_clk,
   input  logic           i_rstn,
   input  logic           i_data_valid,
   input  logic [11:0]    i_data,
   output logic [X_W-1:0] o_centroid_x,
   output logic [Y_W-1:0] o_centroid_y,
   output logic           o_red_object_valid,
   output logic           o_end_frame
);

   localparam logic [X_W-1:0] X_LAST = X_W'(IMG_WIDTH - 1);
   localparam logic [Y_W-1:0] Y_LAST = Y_W'(IMG_HEIGHT - 1);

   logic [X_W-1:0]   x;
   logic [Y_W-1:0]   y;
   logic [SUM_W-1:0] sum_x, sum_y;
   logic [CNT_W-1:0] count, count_lat;
   logic             red, at_last, last_q;
   state_t           state;

   logic             busy_x, busy_y, done_x, done_y;
   logic [SUM_W-1:0] quot_x, quot_y;
   logic             unused_bits;

   assign red     = i_data_valid && is_red(i_data, R_MIN, G_MAX, B_MAX);
   assign at_last = i_data_valid && (x == X_LAST) && (y == Y_LAST);

   // last_q marks the cycle after the last pixel: the dividers sample the
   // finished sums while the accumulators restart with only the current
   // pixel, so no pixel of the next frame is lost.
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         x      <= '0;
         y      <= '0;
         sum_x  <= '0;
         sum_y  <= '0;
         count  <= '0;
         last_q <= 1'b0;
      end else begin
         last_q <= at_last;
         if (i_data_valid) begin
            if (x == X_LAST) begin
               x <= '0;
               y <= (y == Y_LAST) ? '0 : y + Y_W'(1);
            end else begin
               x <= x + X_W'(1);
            end
         end
         if (last_q) begin
            sum_x <= red ? SUM_W'(x) : '0;
            sum_y <= red ? SUM_W'(y) : '0;
            count <= red ? CNT_W'(1) : '0;
         end else if (red) begin
            sum_x <= sum_x + SUM_W'(x);
            sum_y <= sum_y + SUM_W'(y);
            count <= count + CNT_W'(1);
         end
      end
   end

   seq_divider u_div_x (
      .clk      (i_clk),
      .rst_n    (i_rstn),
      .start    (last_q),
      .dividend (sum_x),
      .divisor  (count),
      .busy     (busy_x),
      .done     (done_x),
      .quotient (quot_x)
   );

   seq_divider u_div_y (
      .clk      (i_clk),
      .rst_n    (i_rstn),
      .start    (last_q),
      .dividend (sum_y),
      .divisor  (count),
      .busy     (busy_y),
      .done     (done_y),
      .quotient (quot_y)
   );

   // Quotients never exceed the frame size, so only the low bits are published.
   assign unused_bits = ^{busy_x, busy_y, quot_x[SUM_W-1:X_W], quot_y[SUM_W-1:Y_W]};

   // Outputs are written on the edge entering PUBLISH, so they are already
   // valid during the PUBLISH cycle alongside o_end_frame. A new frame end
   // restarts the dividers from any state, discarding the old result.
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         state              <= ST_ACCUM;
         count_lat          <= '0;
         o_centroid_x       <= '0;
         o_centroid_y       <= '0;
         o_red_object_valid <= 1'b0;
         o_end_frame        <= 1'b0;
      end else begin
         o_end_frame <= 1'b0;
         if (last_q) begin
            state     <= ST_DIVIDE;
            count_lat <= count;
         end else begin
            case (state)
               ST_ACCUM: ;
               ST_DIVIDE: begin
                  if (done_x && done_y) begin
                     state       <= ST_PUBLISH;
                     o_end_frame <= 1'b1;
                     if (count_lat >= CNT_W'(MIN_PIXELS)) begin
                        o_centroid_x       <= quot_x[X_W-1:0];
                        o_centroid_y       <= quot_y[Y_W-1:0];
                        o_red_object_valid <= 1'b1;
                     end else begin
                        o_red_object_valid <= 1'b0;
                     end
                  end
               end
               ST_PUBLISH: state <= ST_ACCUM;
               default:    state <= ST_ACCUM;
            endcase
         end
      end
   end

endmodule

// File: doc/red_centroid_calc.md
RED_CENTROID_CALC -- requirements
Module: red_centroid_calc

Interface
REQ-001 Parameter IMG_WIDTH, 640, active pixels per line.
REQ-002 Parameter IMG_HEIGHT, 480, active lines per frame.
REQ-003 Parameter R_MIN, 4'hA, minimum red nibble for a red pixel.
REQ-004 Parameter G_MAX, 4'h5, maximum green nibble for a red pixel.
REQ-005 Parameter B_MAX, 4'h5, maximum blue nibble for a red pixel.
REQ-006 Parameter MIN_PIXELS, 64, minimum red-pixel count for a valid object.
REQ-007 i_clk  in  1  single clock; all logic on rising edge.
REQ-008 i_rstn  in  1  reset, asynchronous, active-low.
REQ-009 i_data_valid  in  1  qualifies i_data; one pixel accepted per high cycle.
REQ-010 i_data  in  12  RGB444 pixel: [11:8] R, [7:4] G, [3:0] B; raster order.
REQ-011 o_centroid_x  out  10  centroid column of the last completed frame.
REQ-012 o_centroid_y  out  9  centroid row of the last completed frame.
REQ-013 o_red_object_valid  out  1  last completed frame contained a valid object.
REQ-014 o_end_frame  out  1  one-cycle pulse: centroid outputs updated.

Function
REQ-015 Pixel red iff R>=R_MIN and G<=G_MAX and B<=B_MAX, evaluated only when i_data_valid=1.
REQ-016 Internal x counter (10b) increments per accepted pixel and wraps IMG_WIDTH-1 -> 0, incrementing y counter (9b); y wraps IMG_HEIGHT-1 -> 0.
REQ-017 Per red pixel: sum_x += x, sum_y += y, count += 1; sum_x, sum_y 28b unsigned, count 19b; no overflow possible at defaults.
REQ-018 Last pixel = accepted pixel at (IMG_WIDTH-1, IMG_HEIGHT-1), including its own red contribution.
REQ-019 Cycle after last pixel: sums and count copied to divider operands and accumulators cleared in the same cycle; next frame accumulates with no lost pixels.
REQ-020 Control FSM states: ACCUM (idle/accumulating), DIVIDE (divider busy), PUBLISH (one cycle, outputs written).
REQ-021 ACCUM -> DIVIDE on operand latch; DIVIDE -> PUBLISH when divider done; PUBLISH -> ACCUM unconditionally; pixel accumulation continues in every state.
REQ-022 Divider: restoring, unsigned, 28-bit dividend / 19-bit divisor, exactly 28 cycles, x and y divided in parallel; quotient truncated (floor).
REQ-023 o_end_frame rises exactly 30 cycles after the edge accepting the last pixel and is high 1 cycle.
REQ-024 In PUBLISH: if count>=MIN_PIXELS then o_centroid_x/y = low 10/9 bits of quotients and o_red_object_valid=1; else o_red_object_valid=0 and centroid outputs hold previous values.
REQ-025 count=0: divider still runs, result discarded, no divide-by-zero X propagation; o_red_object_valid=0.
REQ-026 Frame end while in DIVIDE: current division aborted, restarted with new operands, one o_end_frame only for the new frame.
REQ-027 All outputs registered and stable between o_end_frame pulses.

Reset
REQ-028 i_rstn low: FSM->ACCUM, x/y counters, sums, count, divider state, all outputs -> 0, asynchronously.
REQ-029 Reset mid-frame or mid-divide: partial frame discarded, no o_end_frame; first frame after release starts at pixel (0,0).

Structure
REQ-030 Shared package holds IMG_WIDTH/IMG_HEIGHT defaults, accumulator/count widths (28/19), divider cycle count (28), FSM state encoding.
REQ-031 One sub-module seq_divider (start, dividend, divisor, busy, done, quotient); two instances, x and y.

Verification
REQ-032 All-black frame (12'h000) -> o_end_frame 30 cycles after last pixel, o_red_object_valid=0, centroid 0/0.
REQ-033 Frame with 9x9 block 12'hF00 centred (100,200) -> o_centroid_x=100, o_centroid_y=200, valid=1.
REQ-034 Frame with 2x2 block 12'hF00 at x=10..11, y=20..21 (count 4 <64) -> valid=0, centroid holds prior 100/200.
REQ-035 64 red pixels row 0: 32 at x=0, 32 at x=1 (across rows 0..31) -> centroid_x=0 (floor of 0.5), valid=1; pixel 12'hA55 red, 12'h9F0 not.
REQ-036 Assert i_rstn low mid-divide, release, drive one full frame with 9x9 block at (300,400) -> single o_end_frame, 300/400, valid=1.
REQ-037 Back-to-back frames with i_data_valid gaps random 0-3 cycles -> each frame yields correct centroid, one pulse per frame.
